// File: rtl/figuras_gato_pkg.sv
// Shared types and constants for the tic-tac-toe pixel generator:
// cell states, colours, board geometry, mark dimensions and command codes.
package figuras_gato_pkg;

   // Content of one board cell
   typedef enum logic [1:0] {
      CELDA_VACIA = 2'd0,
      CELDA_X     = 2'd1,
      CELDA_O     = 2'd2
   } celda_t;

   // Colours, bit 2 = R, bit 1 = G, bit 0 = B
   localparam logic [2:0] NEGRO  = 3'b000;
   localparam logic [2:0] BLANCO = 3'b111;
   localparam logic [2:0] ROJO   = 3'b100;
   localparam logic [2:0] AZUL   = 3'b001;
   localparam logic [2:0] VERDE  = 3'b010;

   // Board placement in screen coordinates
   localparam logic [9:0] ORG_X   = 10'd160;
   localparam logic [9:0] ORG_Y   = 10'd120;
   localparam logic [9:0] CELDA_W = 10'd100;
   localparam logic [9:0] CELDA_H = 10'd80;
   localparam logic [9:0] FIN_X   = 10'd459;
   localparam logic [9:0] FIN_Y   = 10'd359;

   // Column / row boundaries (start of columns 1, 2 and rows 1, 2)
   localparam logic [9:0] COL1_X = ORG_X + CELDA_W;
   localparam logic [9:0] COL2_X = ORG_X + 10'd2 * CELDA_W;
   localparam logic [9:0] FIL1_Y = ORG_Y + CELDA_H;
   localparam logic [9:0] FIL2_Y = ORG_Y + 10'd2 * CELDA_H;

   // Grid: outer frame thickness and inner bar ranges
   localparam logic [9:0] MARCO     = 10'd2;
   localparam logic [9:0] VBAR0_INI = 10'd258;
   localparam logic [9:0] VBAR0_FIN = 10'd261;
   localparam logic [9:0] VBAR1_INI = 10'd358;
   localparam logic [9:0] VBAR1_FIN = 10'd361;
   localparam logic [9:0] HBAR0_INI = 10'd198;
   localparam logic [9:0] HBAR0_FIN = 10'd201;
   localparam logic [9:0] HBAR1_INI = 10'd278;
   localparam logic [9:0] HBAR1_FIN = 10'd281;

   // X mark: bounding box in cell-local coordinates, anti-diagonal sum, stroke half-width
   localparam logic [7:0] X_U_INI  = 8'd20;
   localparam logic [7:0] X_U_FIN  = 8'd79;
   localparam logic [7:0] X_V_INI  = 8'd10;
   localparam logic [7:0] X_V_FIN  = 8'd69;
   localparam logic [7:0] X_DIAG   = 8'd59;
   localparam logic [7:0] X_GROSOR = 8'd2;

   // O mark: centre and squared inner/outer radii (22^2, 28^2)
   localparam logic [7:0]  O_CU     = 8'd50;
   localparam logic [7:0]  O_CV     = 8'd40;
   localparam logic [12:0] O_R2_MIN = 13'd484;
   localparam logic [12:0] O_R2_MAX = 13'd784;

   // Command codes on entrada
   localparam logic [3:0] CMD_CELDA_MAX = 4'd9;
   localparam logic [3:0] CMD_LIMPIAR   = 4'd15;

   // The 8 winning lines as masks over cell index k = 3*row + col
   localparam logic [8:0] LINEAS [8] = '{
      9'b000_000_111,   // row 0
      9'b000_111_000,   // row 1
      9'b111_000_000,   // row 2
      9'b001_001_001,   // column 0
      9'b010_010_010,   // column 1
      9'b100_100_100,   // column 2
      9'b100_010_001,   // diagonal 0,4,8
      9'b001_010_100    // diagonal 2,4,6
   };

   // Unsigned absolute difference
   function automatic logic [7:0] abs_dif(input logic [7:0] a, input logic [7:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/figuras_gato_celda.sv
// Combinational mark renderer for a single cell: given cell-local (u, v),
// the cell content and its win flag, reports whether the pixel is part of
// the mark and which colour it takes.
module figuras_gato_celda
   import figuras_gato_pkg::*;
(
   input  logic [6:0] u,
   input  logic [6:0] v,
   input  celda_t     estado,
   input  logic       ganadora,
   output logic       marca_on,
   output logic [2:0] color
);

   logic [7:0]  uu;
   logic [7:0]  vv;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        zona_x;
   logic        diag_p;
   logic        diag_s;
   logic        marca_x;
   logic [7:0]  du;
   logic [7:0]  dv;
   logic [11:0] sq_u;
   logic [11:0] sq_v;
   logic [12:0] r2;
   logic        anillo;

   // X strokes, O ring and resulting colour
   always_comb begin
      uu = {1'b0, u};
      vv = {1'b0, v};

      zona_x = (uu >= X_U_INI) && (uu <= X_U_FIN) && (vv >= X_V_INI) && (vv <= X_V_FIN);
      a      = uu - X_U_INI;
      b      = vv - X_V_INI;
      diag_p = abs_dif(a, b) <= X_GROSOR;
      diag_s = abs_dif(a + b, X_DIAG) <= X_GROSOR;
      marca_x = zona_x && (diag_p || diag_s);

      du     = abs_dif(uu, O_CU);
      dv     = abs_dif(vv, O_CV);
      sq_u   = {4'b0000, du} * {4'b0000, du};
      sq_v   = {4'b0000, dv} * {4'b0000, dv};
      r2     = {1'b0, sq_u} + {1'b0, sq_v};
      anillo = (r2 >= O_R2_MIN) && (r2 <= O_R2_MAX);

      marca_on = ((estado == CELDA_X) && marca_x) || ((estado == CELDA_O) && anillo);

      color = NEGRO;
      if (marca_on) begin
         if (ganadora)                color = VERDE;
         else if (estado == CELDA_X)  color = ROJO;
         else                         color = AZUL;
      end
   end

endmodule

// File: rtl/figuras_gato.sv
// Tic-tac-toe pixel generator: board state, edge-triggered command decode,
// win/draw detection and a registered RGB output for the current pixel.
module figuras_gato
   import figuras_gato_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       video_mostrar,
   input  logic [3:0] entrada,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic [2:0] salida_rgb
);

   celda_t     tablero_q [9];
   celda_t     tablero_d [9];
   celda_t     turno_q;
   celda_t     turno_d;
   logic       fin_q;
   logic       fin_d;
   logic [8:0] gana_q;
   logic [8:0] gana_d;
   logic [3:0] entrada_prev_q;
   logic [3:0] entrada_prev_d;
   logic [2:0] salida_rgb_q;
   logic [2:0] salida_rgb_d;

   logic       acepta;
   logic [3:0] celda_sel;
   logic [8:0] marcas_x;
   logic [8:0] marcas_o;
   logic [8:0] gana_eval;
   logic       fin_eval;

   logic       en_tablero;
   logic       es_rejilla;
   logic [1:0] col;
   logic [1:0] fila;
   logic [9:0] base_x;
   logic [9:0] base_y;
   logic [6:0] u;
   logic [6:0] v;
   logic [3:0] idx;
   celda_t     estado_pix;
   logic       ganadora_pix;
   logic       marca_on;
   logic [2:0] color_celda;

   // Line evaluation on the registered board; lands in fin/gana one cycle after a move
   always_comb begin
      marcas_x = '0;
      marcas_o = '0;
      for (int unsigned k = 0; k < 9; k++) begin
         marcas_x[k] = (tablero_q[k] == CELDA_X);
         marcas_o[k] = (tablero_q[k] == CELDA_O);
      end
      gana_eval = '0;
      for (int unsigned l = 0; l < 8; l++) begin
         if (((marcas_x & LINEAS[l]) == LINEAS[l]) || ((marcas_o & LINEAS[l]) == LINEAS[l]))
            gana_eval = gana_eval | LINEAS[l];
      end
      fin_eval = (|gana_eval) || (&(marcas_x | marcas_o));
   end

   // Command decode on the 0 -> nonzero transition of entrada
   always_comb begin
      entrada_prev_d = entrada;
      tablero_d      = tablero_q;
      turno_d        = turno_q;
      fin_d          = fin_eval;
      gana_d         = gana_eval;
      acepta         = (entrada_prev_q == '0) && (entrada != '0);
      celda_sel      = entrada - 4'd1;

      if (acepta) begin
         if (entrada == CMD_LIMPIAR) begin
            for (int unsigned k = 0; k < 9; k++) tablero_d[k] = CELDA_VACIA;
            turno_d = CELDA_X;
            fin_d   = 1'b0;
            gana_d  = '0;
         end else if (entrada <= CMD_CELDA_MAX) begin
            if ((tablero_q[celda_sel] == CELDA_VACIA) && !fin_q) begin
               tablero_d[celda_sel] = turno_q;
               turno_d = (turno_q == CELDA_X) ? CELDA_O : CELDA_X;
            end
         end
      end
   end

   // Cell selection and cell-local coordinates for the current pixel
   always_comb begin
      en_tablero = (pixel_x >= ORG_X) && (pixel_x <= FIN_X) &&
                   (pixel_y >= ORG_Y) && (pixel_y <= FIN_Y);

      if (pixel_x < COL1_X)      begin col = 2'd0; base_x = ORG_X;  end
      else if (pixel_x < COL2_X) begin col = 2'd1; base_x = COL1_X; end
      else                       begin col = 2'd2; base_x = COL2_X; end

      if (pixel_y < FIL1_Y)      begin fila = 2'd0; base_y = ORG_Y;  end
      else if (pixel_y < FIL2_Y) begin fila = 2'd1; base_y = FIL1_Y; end
      else                       begin fila = 2'd2; base_y = FIL2_Y; end

      u   = 7'(pixel_x - base_x);
      v   = 7'(pixel_y - base_y);
      idx = ({2'b00, fila} * 4'd3) + {2'b00, col};

      // Off-board pixels can map past cell 8; they are masked by en_tablero anyway
      if (idx <= 4'd8) begin
         estado_pix   = tablero_q[idx];
         ganadora_pix = gana_q[idx];
      end else begin
         estado_pix   = CELDA_VACIA;
         ganadora_pix = 1'b0;
      end

      es_rejilla = en_tablero && (
                   (pixel_x < ORG_X + MARCO) || (pixel_x > FIN_X - MARCO) ||
                   (pixel_y < ORG_Y + MARCO) || (pixel_y > FIN_Y - MARCO) ||
                   ((pixel_x >= VBAR0_INI) && (pixel_x <= VBAR0_FIN)) ||
                   ((pixel_x >= VBAR1_INI) && (pixel_x <= VBAR1_FIN)) ||
                   ((pixel_y >= HBAR0_INI) && (pixel_y <= HBAR0_FIN)) ||
                   ((pixel_y >= HBAR1_INI) && (pixel_y <= HBAR1_FIN)));
   end

   figuras_gato_celda u_celda (
      .u        (u),
      .v        (v),
      .estado   (estado_pix),
      .ganadora (ganadora_pix),
      .marca_on (marca_on),
      .color    (color_celda)
   );

   // Colour priority: blanking, grid, marks, background
   always_comb begin
      salida_rgb_d = NEGRO;
      if (video_mostrar) begin
         if (es_rejilla)                  salida_rgb_d = BLANCO;
         else if (en_tablero && marca_on) salida_rgb_d = color_celda;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < 9; k++) tablero_q[k] <= CELDA_VACIA;
         turno_q        <= CELDA_X;
         fin_q          <= 1'b0;
         gana_q         <= '0;
         entrada_prev_q <= '0;
         salida_rgb_q   <= NEGRO;
      end else begin
         tablero_q      <= tablero_d;
         turno_q        <= turno_d;
         fin_q          <= fin_d;
         gana_q         <= gana_d;
         entrada_prev_q <= entrada_prev_d;
         salida_rgb_q   <= salida_rgb_d;
      end
   end

   assign salida_rgb = salida_rgb_q;

endmodule

// File: tb/tb_figuras_gato.sv
// Self-checking bench for figuras_gato: a behavioural board model predicts
// the colour of every probed pixel; predictions go through a queue and are
// compared against the registered RGB output one clock later.
module tb_figuras_gato;

   logic       clk = 1'b0;
   logic       reset;
   logic       video_mostrar;
   logic [3:0] entrada;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic [2:0] salida_rgb;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: 0 empty, 1 X, 2 O
   int tablero [9];
   int gana    [9];
   int turno;
   bit fin;

   logic [2:0] esperado_q [$];

   always #5 clk = ~clk;

   figuras_gato dut (
      .clk           (clk),
      .reset         (reset),
      .video_mostrar (video_mostrar),
      .entrada       (entrada),
      .pixel_x       (pixel_x),
      .pixel_y       (pixel_y),
      .salida_rgb    (salida_rgb)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   function automatic void modelo_reset();
      for (int k = 0; k < 9; k++) begin
         tablero[k] = 0;
         gana[k]    = 0;
      end
      turno = 1;
      fin   = 1'b0;
   endfunction

   function automatic void modelo_evaluar();
      int lin [8][3];
      bit lleno;
      lin = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      for (int k = 0; k < 9; k++) gana[k] = 0;
      fin   = 1'b0;
      lleno = 1'b1;
      for (int k = 0; k < 9; k++) if (tablero[k] == 0) lleno = 1'b0;
      for (int l = 0; l < 8; l++) begin
         if (tablero[lin[l][0]] != 0 &&
             tablero[lin[l][0]] == tablero[lin[l][1]] &&
             tablero[lin[l][1]] == tablero[lin[l][2]]) begin
            fin = 1'b1;
            for (int j = 0; j < 3; j++) gana[lin[l][j]] = 1;
         end
      end
      if (lleno) fin = 1'b1;
   endfunction

   function automatic void modelo_comando(input int code);
      if (code == 15) begin
         modelo_reset();
      end else if (code >= 1 && code <= 9) begin
         if (tablero[code-1] == 0 && !fin) begin
            tablero[code-1] = turno;
            turno = (turno == 1) ? 2 : 1;
            modelo_evaluar();
         end
      end
   endfunction

   function automatic logic [2:0] color_modelo(input int x, input int y, input bit vm);
      int col, fila, u, v, k, r2;
      bit xon, oon;
      if (!vm) return 3'b000;
      if (x < 160 || x > 459 || y < 120 || y > 359) return 3'b000;
      if (x <= 161 || x >= 458 || y <= 121 || y >= 358 ||
          (x >= 258 && x <= 261) || (x >= 358 && x <= 361) ||
          (y >= 198 && y <= 201) || (y >= 278 && y <= 281)) return 3'b111;
      col  = (x - 160) / 100;
      fila = (y - 120) / 80;
      u    = x - 160 - 100 * col;
      v    = y - 120 - 80 * fila;
      k    = 3 * fila + col;
      xon  = (u >= 20 && u <= 79 && v >= 10 && v <= 69) &&
             (iabs((u - 20) - (v - 10)) <= 2 || iabs((u - 20) + (v - 10) - 59) <= 2);
      r2   = (u - 50) * (u - 50) + (v - 40) * (v - 40);
      oon  = (r2 >= 484 && r2 <= 784);
      if ((tablero[k] == 1 && xon) || (tablero[k] == 2 && oon)) begin
         if (gana[k] != 0)      return 3'b010;
         if (tablero[k] == 1)   return 3'b100;
         return 3'b001;
      end
      return 3'b000;
   endfunction

   task automatic pixel(input string tag, input int x, input int y, input bit vm);
      logic [2:0] exp;
      pixel_x       = 10'(x);
      pixel_y       = 10'(y);
      video_mostrar = vm;
      esperado_q.push_back(color_modelo(x, y, vm));
      tick();
      exp = esperado_q.pop_front();
      chk(tag, salida_rgb, exp);
   endtask

   task automatic barrido(input int n);
      int x, y;
      for (int i = 0; i < n; i++) begin
         if (i % 4 == 0) begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
         end else begin
            x = $urandom_range(150, 470);
            y = $urandom_range(110, 370);
         end
         pixel($sformatf("scan(%0d,%0d)", x, y), x, y, 1'b1);
      end
   endtask

   task automatic comando(input int code, input int ciclos);
      entrada = 4'(code);
      modelo_comando(code);
      repeat (ciclos) tick();
      entrada = 4'd0;
      tick();
      tick();
   endtask

   initial begin
      reset         = 1'b1;
      entrada       = 4'd0;
      video_mostrar = 1'b1;
      pixel_x       = 10'd160;
      pixel_y       = 10'd120;
      modelo_reset();

      // Output register held at black under reset even on a grid pixel
      esperado_q.push_back(3'b000);
      tick();
      chk("reset_rgb", salida_rgb, esperado_q.pop_front());
      reset = 1'b0;

      // Idle board, blanking and grid boundaries
      pixel("grid_origin", 160, 120, 1'b1);
      pixel("empty_cell", 200, 150, 1'b1);
      pixel("outside", 50, 50, 1'b1);
      pixel("blanking", 160, 120, 1'b0);
      pixel("frame_161", 161, 200, 1'b1);
      pixel("inside_162", 162, 130, 1'b1);
      pixel("corner_459", 459, 359, 1'b1);
      pixel("right_460", 460, 359, 1'b1);
      pixel("vbar_257", 257, 150, 1'b1);
      pixel("vbar_258", 258, 150, 1'b1);
      pixel("vbar_261", 261, 150, 1'b1);
      pixel("vbar_262", 262, 150, 1'b1);
      pixel("hbar_197", 300, 197, 1'b1);
      pixel("hbar_198", 300, 198, 1'b1);
      pixel("hbar_281", 300, 281, 1'b1);
      pixel("hbar_282", 300, 282, 1'b1);

      // X in cell 0, code held for 5 clocks
      comando(1, 5);
      pixel("x_corner", 180, 130, 1'b1);
      pixel("x_centre", 210, 160, 1'b1);
      pixel("x_edge_in", 182, 130, 1'b1);
      pixel("x_edge_out", 183, 130, 1'b1);
      pixel("x_antidiag", 239, 130, 1'b1);

      // O in cell 4, ring radius boundaries
      comando(5, 1);
      pixel("o_r625", 310, 215, 1'b1);
      pixel("o_r484", 310, 218, 1'b1);
      pixel("o_r441", 310, 219, 1'b1);
      pixel("o_r784", 310, 212, 1'b1);
      pixel("o_r841", 310, 211, 1'b1);

      // Occupied cell ignored, turn stays with X
      comando(5, 1);
      comando(2, 1);
      pixel("turn_x_cell1", 310, 160, 1'b1);
      barrido(60);

      // Clear
      comando(15, 1);
      pixel("clear_cell0", 180, 130, 1'b1);
      barrido(40);

      // X wins top row
      comando(1, 1);
      comando(4, 1);
      comando(2, 1);
      comando(5, 1);
      comando(3, 1);
      pixel("win_cell0", 180, 130, 1'b1);
      pixel("win_cell4_o", 310, 215, 1'b1);
      comando(9, 1);
      pixel("after_fin_380_300", 380, 300, 1'b1);
      pixel("after_fin_ring", 410, 298, 1'b1);
      for (int c = 10; c <= 14; c++) comando(c, 1);
      barrido(80);

      // Clear while game over
      comando(15, 1);
      pixel("clear_fin_cell0", 180, 130, 1'b1);
      comando(9, 1);
      pixel("after_clear_x", 410, 320, 1'b1);
      comando(15, 1);

      // Draw: full board, no green
      comando(1, 1); comando(2, 1); comando(3, 1);
      comando(5, 1); comando(4, 1); comando(6, 1);
      comando(8, 1); comando(7, 1); comando(9, 1);
      barrido(80);
      comando(15, 1);

      // Reset mid-game overrides a command on the same edge
      comando(1, 1);
      comando(5, 1);
      pixel("pre_reset_x", 180, 130, 1'b1);
      reset   = 1'b1;
      entrada = 4'd1;
      pixel_x = 10'd180;
      pixel_y = 10'd130;
      esperado_q.push_back(3'b000);
      tick();
      chk("reset_mid_rgb", salida_rgb, esperado_q.pop_front());
      reset   = 1'b0;
      entrada = 4'd0;
      modelo_reset();
      tick();
      pixel("reset_cell0", 180, 130, 1'b1);
      pixel("reset_cell4", 310, 215, 1'b1);
      barrido(30);

      chk("queue_empty", esperado_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
